kplic_arbiter: RTL and testbench

Central arbitration and claim/complete controller of the KPLIC, sitting between the per-source gateways and the hart's external-interrupt input. It latches each gateway's `valid_int_req` into a pending bit and selects the highest-priority pending source above the hart threshold. It raises `ext_int_notify` to the core, serves claim requests from the register block, and routes completions back to the originating gateway as a one-cycle `int_completion` pulse.

---
 rtl/kplic_arbiter_pkg.sv | 16 +
 rtl/kplic_max_sel.sv | 28 ++
 rtl/kplic_arbiter.sv | 129 ++++++++++++
 tb/tb_kplic_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kplic_arbiter_pkg.sv
// Shared constants for the KPLIC arbiter: build-time defaults and the "no source" ID.
package kplic_arbiter_pkg;

    // Default build configuration for the single-hart target.
    localparam int unsigned KPLIC_NUM_SRC = 16;
    localparam int unsigned KPLIC_PRIO_W  = 3;

    // Source ID 0 is reserved to mean "no interrupt".
    localparam int unsigned KPLIC_ID_NONE = 0;

    // True when an ID names a real source (1..num_src).
    function automatic bit kplic_id_in_range(input int unsigned id, input int unsigned num_src);
        return (id != KPLIC_ID_NONE) && (id <= num_src);
    endfunction

endpackage

// File: rtl/kplic_max_sel.sv
// Combinational selector: highest-priority pending source, lowest ID on ties.
// Priority 0 never qualifies; with no qualifying source the result is ID 0, priority 0.
module kplic_max_sel
    import kplic_arbiter_pkg::*;
#(
    parameter int unsigned NUM_SRC = KPLIC_NUM_SRC,
    parameter int unsigned PRIO_W  = KPLIC_PRIO_W,
    parameter int unsigned ID_W    = $clog2(NUM_SRC + 1)
) (
    input  logic [NUM_SRC-1:0]        pending,
    input  logic [NUM_SRC*PRIO_W-1:0] int_priority,
    output logic [ID_W-1:0]           best_id,
    output logic [PRIO_W-1:0]         best_prio
);

    // Ascending scan with a strict compare keeps the lowest ID on ties and skips priority 0.
    always_comb begin
        best_id   = ID_W'(KPLIC_ID_NONE);
        best_prio = '0;
        for (int i = 0; i < int'(NUM_SRC); i++) begin
            if (pending[i] && (int_priority[i*PRIO_W +: PRIO_W] > best_prio)) begin
                best_id   = ID_W'(i + 1);
                best_prio = int_priority[i*PRIO_W +: PRIO_W];
            end
        end
    end

endmodule

// File: rtl/kplic_arbiter.sv
// KPLIC central arbiter: pending/in-service tracking, best-source selection,
// claim/complete handshake with the register block and notify to the hart.
module kplic_arbiter
    import kplic_arbiter_pkg::*;
#(
    parameter int unsigned NUM_SRC = KPLIC_NUM_SRC,
    parameter int unsigned PRIO_W  = KPLIC_PRIO_W,
    parameter int unsigned ID_W    = $clog2(NUM_SRC + 1)
) (
    input  logic                      kplic_clk,
    input  logic                      kplic_rstn,
    input  logic [NUM_SRC-1:0]        valid_int_req,
    input  logic [NUM_SRC*PRIO_W-1:0] int_priority,
    input  logic [PRIO_W-1:0]         prio_threshold,
    input  logic                      claim_req,
    output logic                      claim_ack,
    output logic [ID_W-1:0]           claim_id,
    input  logic                      complete_req,
    input  logic [ID_W-1:0]           complete_id,
    output logic [NUM_SRC-1:0]        int_completion,
    output logic                      ext_int_notify
);

    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic [NUM_SRC-1:0] in_service_q, in_service_d;
    logic [NUM_SRC-1:0] claim_clr;
    logic [NUM_SRC-1:0] compl_vec;
    logic [NUM_SRC-1:0] int_completion_q;

    logic [ID_W-1:0]    best_id_q, best_id_d;
    logic [PRIO_W-1:0]  best_prio_q, best_prio_d;
    logic [PRIO_W-1:0]  threshold_q;

    logic [ID_W-1:0]    claim_id_q, claim_id_d;
    logic               claim_ack_q;
    logic               claim_fire;
    logic               notify_q, notify_d;

    // Claim is granted only if the registered winner beats the live threshold.
    always_comb begin
        claim_fire = claim_req && (best_prio_q > prio_threshold);
        claim_clr  = '0;
        for (int i = 0; i < int'(NUM_SRC); i++) begin
            if (claim_fire && (best_id_q == ID_W'(i + 1))) begin
                claim_clr[i] = 1'b1;
            end
        end
        claim_id_d = claim_id_q;
        if (claim_req) begin
            claim_id_d = claim_fire ? best_id_q : ID_W'(KPLIC_ID_NONE);
        end
    end

    // Completion only acts on an in-service source; ID 0 or out-of-range never matches.
    always_comb begin
        compl_vec = '0;
        for (int i = 0; i < int'(NUM_SRC); i++) begin
            if (complete_req && (complete_id == ID_W'(i + 1)) && in_service_q[i]) begin
                compl_vec[i] = 1'b1;
            end
        end
    end

    // Next pending/in-service state; a new request outranks a same-cycle claim clear,
    // and a same-cycle complete of the source being claimed sees in_service_q still 0.
    always_comb begin
        pending_d    = valid_int_req | (pending_q & ~claim_clr);
        in_service_d = (in_service_q & ~compl_vec) | claim_clr;
        notify_d     = (best_prio_q > threshold_q);
    end

    // Selection runs on pending_d so best_*_q always describes pending_q.
    kplic_max_sel #(
        .NUM_SRC (NUM_SRC),
        .PRIO_W  (PRIO_W),
        .ID_W    (ID_W)
    ) u_max_sel (
        .pending      (pending_d),
        .int_priority (int_priority),
        .best_id      (best_id_d),
        .best_prio    (best_prio_d)
    );

    // Source state and arbitration result registers.
    always_ff @(posedge kplic_clk or negedge kplic_rstn) begin
        if (!kplic_rstn) begin
            pending_q    <= '0;
            in_service_q <= '0;
            best_id_q    <= '0;
            best_prio_q  <= '0;
        end else begin
            pending_q    <= pending_d;
            in_service_q <= in_service_d;
            best_id_q    <= best_id_d;
            best_prio_q  <= best_prio_d;
        end
    end

    // Threshold is registered so a threshold change reaches notify with the same
    // two-cycle latency as a priority change.
    always_ff @(posedge kplic_clk or negedge kplic_rstn) begin
        if (!kplic_rstn) begin
            threshold_q <= '0;
            notify_q    <= 1'b0;
        end else begin
            threshold_q <= prio_threshold;
            notify_q    <= notify_d;
        end
    end

    // Handshake outputs back to the register block and gateways.
    always_ff @(posedge kplic_clk or negedge kplic_rstn) begin
        if (!kplic_rstn) begin
            claim_ack_q      <= 1'b0;
            claim_id_q       <= '0;
            int_completion_q <= '0;
        end else begin
            claim_ack_q      <= claim_req;
            claim_id_q       <= claim_id_d;
            int_completion_q <= compl_vec;
        end
    end

    assign claim_ack      = claim_ack_q;
    assign claim_id       = claim_id_q;
    assign int_completion = int_completion_q;
    assign ext_int_notify = notify_q;

endmodule

// File: tb/tb_kplic_arbiter.sv
// Self-checking bench for kplic_arbiter: fixed vector table, directed corner
// sequences, then random traffic against a behavioural model.
module tb_kplic_arbiter;

    localparam int NS = 16;
    localparam int PW = 3;
    localparam int IW = 5;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic [NS-1:0]     valid_int_req = '0;
    logic [NS*PW-1:0]  int_priority = '0;
    logic [PW-1:0]     prio_threshold = '0;
    logic              claim_req = 1'b0;
    logic              claim_ack;
    logic [IW-1:0]     claim_id;
    logic              complete_req = 1'b0;
    logic [IW-1:0]     complete_id = '0;
    logic [NS-1:0]     int_completion;
    logic              ext_int_notify;

    always #5 clk = ~clk;

    kplic_arbiter dut (
        .kplic_clk      (clk),
        .kplic_rstn     (rstn),
        .valid_int_req  (valid_int_req),
        .int_priority   (int_priority),
        .prio_threshold (prio_threshold),
        .claim_req      (claim_req),
        .claim_ack      (claim_ack),
        .claim_id       (claim_id),
        .complete_req   (complete_req),
        .complete_id    (complete_id),
        .int_completion (int_completion),
        .ext_int_notify (ext_int_notify)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Behavioural model: arrays of flags plus the last arbitration result.
    bit [NS-1:0] m_pend, m_insvc, m_compl;
    int          m_best_id, m_best_prio, m_thr, m_cid;
    bit          m_ntf, m_ack;

    function automatic int prio_of(input int s);
        return int'(int_priority[(s-1)*PW +: PW]);
    endfunction

    // Highest priority first, then lowest ID among that priority.
    task automatic m_arb(input bit [NS-1:0] pend, output int id, output int pr);
        id = 0;
        pr = 0;
        for (int p = (1 << PW) - 1; p >= 1 && id == 0; p--)
            for (int s = 1; s <= NS && id == 0; s++)
                if (pend[s-1] && prio_of(s) == p) begin
                    id = s;
                    pr = p;
                end
    endtask

    task automatic m_reset();
        m_pend = '0; m_insvc = '0; m_compl = '0;
        m_best_id = 0; m_best_prio = 0; m_thr = 0; m_cid = 0;
        m_ntf = 0; m_ack = 0;
    endtask

    // One clock: evaluate the model on the inputs present now, clock, then commit.
    task automatic tick();
        bit ok;
        bit [NS-1:0] np, ni, nc;
        int nid, npr, ncid, cid;
        bit nn;
        ok = claim_req && (m_best_prio > int'(prio_threshold));
        np = m_pend;
        ni = m_insvc;
        nc = '0;
        if (ok) np[m_best_id-1] = 1'b0;
        np = np | valid_int_req;
        cid = int'(complete_id);
        if (complete_req && cid >= 1 && cid <= NS) begin
            if (m_insvc[cid-1]) begin
                nc[cid-1] = 1'b1;
                ni[cid-1] = 1'b0;
            end
        end
        if (ok) ni[m_best_id-1] = 1'b1;
        m_arb(np, nid, npr);
        nn = (m_best_prio > m_thr);
        ncid = claim_req ? (ok ? m_best_id : 0) : m_cid;
        @(posedge clk);
        #1;
        if (!rstn) m_reset();
        else begin
            m_thr = int'(prio_threshold);
            m_pend = np; m_insvc = ni; m_compl = nc;
            m_best_id = nid; m_best_prio = npr;
            m_ntf = nn; m_ack = claim_req; m_cid = ncid;
        end
    endtask

    task automatic drive(input logic [NS-1:0] v, input logic cl, input logic cp, input int cid);
        valid_int_req = v;
        claim_req     = cl;
        complete_req  = cp;
        complete_id   = IW'(cid);
    endtask

    task automatic set_prio(input int s, input int p);
        int_priority[(s-1)*PW +: PW] = PW'(p);
    endtask

    task automatic do_reset();
        drive('0, 0, 0, 0);
        rstn = 1'b0;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    typedef struct packed {
        logic [NS-1:0] valid;
        logic          claim;
        logic          comp;
        logic [IW-1:0] cid;
        logic          ack_e;
        logic [IW-1:0] id_e;
        logic          ntf_e;
        logic [NS-1:0] cmpl_e;
    } vec_t;

    vec_t tbl [10];

    initial begin
        // Sources 3 (prio 2) and 5 (prio 6), threshold 1, both requested together.
        tbl[0] = '{16'h0014, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 16'h0000};
        tbl[1] = '{16'h0000, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 16'h0000};
        tbl[2] = '{16'h0000, 1'b1, 1'b0, 5'd0, 1'b1, 5'd5, 1'b1, 16'h0000};
        tbl[3] = '{16'h0000, 1'b1, 1'b0, 5'd0, 1'b1, 5'd3, 1'b1, 16'h0000};
        tbl[4] = '{16'h0000, 1'b1, 1'b0, 5'd0, 1'b1, 5'd0, 1'b0, 16'h0000};
        tbl[5] = '{16'h0000, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 16'h0000};
        tbl[6] = '{16'h0000, 1'b0, 1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 16'h0010};
        tbl[7] = '{16'h0000, 1'b0, 1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 16'h0000};
        tbl[8] = '{16'h0000, 1'b0, 1'b1, 5'd3, 1'b0, 5'd0, 1'b0, 16'h0004};
        tbl[9] = '{16'h0000, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 16'h0000};

        // Reset state.
        m_reset();
        #1;
        check("rst ack", 32'(claim_ack), 32'd0);
        check("rst id", 32'(claim_id), 32'd0);
        check("rst notify", 32'(ext_int_notify), 32'd0);
        check("rst compl", 32'(int_completion), 32'd0);

        // Table sequence.
        set_prio(3, 2);
        set_prio(5, 6);
        prio_threshold = 3'd1;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            drive(tbl[i].valid, tbl[i].claim, tbl[i].comp, int'(tbl[i].cid));
            tick();
            check($sformatf("tbl%0d ack", i), 32'(claim_ack), 32'(tbl[i].ack_e));
            check($sformatf("tbl%0d id", i), 32'(claim_id), 32'(tbl[i].id_e));
            check($sformatf("tbl%0d notify", i), 32'(ext_int_notify), 32'(tbl[i].ntf_e));
            check($sformatf("tbl%0d compl", i), 32'(int_completion), 32'(tbl[i].cmpl_e));
        end

        // Equal priorities: lowest ID wins.
        int_priority = '0;
        set_prio(2, 4);
        set_prio(7, 4);
        prio_threshold = 3'd0;
        do_reset();
        drive(16'h0042, 0, 0, 0); tick();
        drive('0, 0, 0, 0); tick();
        check("tie notify", 32'(ext_int_notify), 32'd1);
        drive('0, 1, 0, 0); tick();
        check("tie first id", 32'(claim_id), 32'd2);
        drive('0, 1, 0, 0); tick();
        check("tie second id", 32'(claim_id), 32'd7);

        // Priority equal to threshold does not qualify; lowering threshold does.
        int_priority = '0;
        set_prio(4, 3);
        prio_threshold = 3'd3;
        do_reset();
        drive(16'h0008, 0, 0, 0); tick();
        drive('0, 0, 0, 0); tick(); tick();
        check("thr notify low", 32'(ext_int_notify), 32'd0);
        drive('0, 1, 0, 0); tick();
        check("thr claim ack", 32'(claim_ack), 32'd1);
        check("thr claim id", 32'(claim_id), 32'd0);
        check("thr pending kept", 32'(dut.pending_q[3]), 32'd1);
        drive('0, 0, 0, 0);
        prio_threshold = 3'd2;
        tick();
        check("thr notify +1", 32'(ext_int_notify), 32'd0);
        tick();
        check("thr notify +2", 32'(ext_int_notify), 32'd1);

        // Completion pulse and ignored completions.
        int_priority = '0;
        set_prio(6, 5);
        prio_threshold = 3'd0;
        do_reset();
        drive(16'h0020, 0, 0, 0); tick();
        drive('0, 1, 0, 0); tick();
        check("cmp claim id", 32'(claim_id), 32'd6);
        drive('0, 0, 1, 6); tick();
        check("cmp pulse", 32'(int_completion), 32'h0020);
        drive('0, 0, 0, 0); tick();
        check("cmp pulse end", 32'(int_completion), 32'h0000);
        drive('0, 0, 1, 6); tick();
        check("cmp again", 32'(int_completion), 32'h0000);
        drive('0, 0, 1, 0); tick();
        check("cmp id0", 32'(int_completion), 32'h0000);
        drive('0, 0, 1, 17); tick();
        check("cmp id17", 32'(int_completion), 32'h0000);

        // New request on the bit being claimed wins over the claim clear.
        int_priority = '0;
        set_prio(1, 1);
        prio_threshold = 3'd0;
        do_reset();
        drive(16'h0001, 0, 0, 0); tick();
        drive('0, 0, 0, 0); tick();
        drive(16'h0001, 1, 0, 0); tick();
        check("setwin id", 32'(claim_id), 32'd1);
        check("setwin pending", 32'(dut.pending_q[0]), 32'd1);
        drive('0, 1, 0, 0); tick();
        check("setwin reclaim id", 32'(claim_id), 32'd1);

        // Reset one cycle after a claim.
        int_priority = '0;
        set_prio(5, 6);
        do_reset();
        drive(16'h0010, 0, 0, 0); tick();
        drive('0, 0, 0, 0); tick();
        drive('0, 1, 0, 0); tick();
        drive('0, 0, 0, 0);
        rstn = 1'b0;
        m_reset();
        #1;
        check("midrst ack", 32'(claim_ack), 32'd0);
        check("midrst id", 32'(claim_id), 32'd0);
        check("midrst notify", 32'(ext_int_notify), 32'd0);
        check("midrst pending", 32'(dut.pending_q), 32'd0);
        check("midrst insvc", 32'(dut.in_service_q), 32'd0);
        tick();
        rstn = 1'b1;
        tick();
        check("postrst ack", 32'(claim_ack), 32'd0);
        check("postrst id", 32'(claim_id), 32'd0);
        check("postrst notify", 32'(ext_int_notify), 32'd0);
        check("postrst pending", 32'(dut.pending_q), 32'd0);
        check("postrst insvc", 32'(dut.in_service_q), 32'd0);

        // Random traffic against the model.
        for (int s = 1; s <= NS; s++) set_prio(s, int'($urandom_range(0, 7)));
        prio_threshold = PW'($urandom_range(0, 3));
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            logic [NS-1:0] v;
            int cid;
            v = '0;
            for (int b = 0; b < NS; b++) v[b] = ($urandom_range(0, 15) == 0);
            cid = int'($urandom_range(0, 31));
            if ($urandom_range(0, 1) == 1) begin
                for (int b = 0; b < NS; b++)
                    if (m_insvc[b] && $urandom_range(0, 2) == 0) cid = b + 1;
            end
            if (c % 200 == 199) begin
                prio_threshold = PW'($urandom_range(0, 4));
                set_prio(int'($urandom_range(1, NS)), int'($urandom_range(0, 7)));
            end
            drive(v, ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), cid);
            tick();
            check($sformatf("rnd%0d ack", c), 32'(claim_ack), 32'(m_ack));
            check($sformatf("rnd%0d id", c), 32'(claim_id), 32'(m_cid));
            check($sformatf("rnd%0d notify", c), 32'(ext_int_notify), 32'(m_ntf));
            check($sformatf("rnd%0d compl", c), 32'(int_completion), 32'(m_compl));
            check($sformatf("rnd%0d pending", c), 32'(dut.pending_q), 32'(m_pend));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
